// File: rtl/skeeball_pkg.sv
// skeeball_pkg: shared FSM encoding, drop counter width and hit priority helper
package skeeball_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam int DROP_W = 8;
    localparam int PRIO_W = 3;

    function automatic logic [PRIO_W-1:0] lowest_set(input logic [7:0] v);
        logic [PRIO_W-1:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = PRIO_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/sense_debounce.sv
// sense_debounce: two-flop synchroniser, tick-based debounce and rising-edge strobe for one line
module sense_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic          s1, s2, stable;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = tick && (s2 != stable) && (cnt == CW'(DEBOUNCE_TICKS - 1));
    assign rise = flip && s2;

    // synchronise, then let the stable level follow only after enough disagreeing ticks
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable)
                cnt <= '0;
            else if (flip) begin
                stable <= s2;
                cnt    <= '0;
            end else if (tick)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ball_sense_front.sv
// ball_sense_front: debounced multi-hole sensor front end with arbitration, event strobe and lockout
module ball_sense_front
    import skeeball_pkg::*;
#(
    parameter int NUM_HOLES      = 6,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LOCKOUT_TICKS  = 5,
    parameter int ID_W           = 3
) (
    input  logic                 clk,
    input  logic                 Reset_n,
    input  logic                 tick,
    input  logic [NUM_HOLES-1:0] sensor_raw,
    output logic                 sense_pulse,
    output logic [ID_W-1:0]      hole_id,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int LW = $clog2(LOCKOUT_TICKS + 1);

    logic [NUM_HOLES-1:0] rise;
    logic [7:0]           rise8;
    logic                 multi;
    logic                 drop;
    state_t               state;
    logic [LW-1:0]        lock_cnt;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_line
        sense_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
            .clk     (clk),
            .Reset_n (Reset_n),
            .tick    (tick),
            .raw     (sensor_raw[i]),
            .rise    (rise[i])
        );
    end

    assign rise8       = 8'(rise);
    assign multi       = |(rise & (rise - 1'b1));
    assign drop        = (state == IDLE) ? multi : |rise;
    assign sense_pulse = (state == EMIT);
    assign busy        = (state != IDLE);

    // accept the lowest-index edge in IDLE, strobe for one clk, then ignore edges for the lockout
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            hole_id  <= '0;
        end else begin
            case (state)
                IDLE: if (|rise) begin
                    hole_id <= ID_W'(lowest_set(rise8));
                    state   <= EMIT;
                end
                EMIT: begin
                    lock_cnt <= '0;
                    state    <= LOCKOUT;
                end
                LOCKOUT: if (tick) begin
                    if (lock_cnt == LW'(LOCKOUT_TICKS - 1))
                        state <= IDLE;
                    else
                        lock_cnt <= lock_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // count clks that discarded at least one edge, sticking at full scale
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            drop_cnt <= '0;
        else if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end

endmodule

// File: tb/tb_ball_sense_front.sv
// tb_ball_sense_front: vector table, directed corner sequences and random traffic against a reference model
module tb_ball_sense_front;

    localparam int DEB  = 4;
    localparam int LOCK = 5;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] raw = '0;
    logic       sense_pulse;
    logic [2:0] hole_id;
    logic       busy;
    logic [7:0] drop_cnt;

    ball_sense_front #(
        .NUM_HOLES(6), .DEBOUNCE_TICKS(DEB), .LOCKOUT_TICKS(LOCK), .ID_W(3)
    ) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .tick        (tick),
        .sensor_raw  (raw),
        .sense_pulse (sense_pulse),
        .hole_id     (hole_id),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int lock_ticks = 0;
    bit fast = 1'b0;

    logic [5:0] m_s1, m_s2, m_stab;
    int         m_cnt [6];
    int         m_mode, m_left, m_hid, m_drop, m_total;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0;
        for (int h = 0; h < 6; h++) m_cnt[h] = 0;
        m_mode = 0; m_left = 0; m_hid = 0; m_drop = 0;
    endtask

    task automatic model_step(input logic [5:0] r, input logic t);
        logic [5:0] rs;
        int n;
        bit nd;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        rs = '0;
        for (int h = 0; h < 6; h++) begin
            if (m_s2[h] != m_stab[h]) begin
                if (t) begin
                    m_cnt[h]++;
                    if (m_cnt[h] == DEB) begin
                        m_stab[h] = m_s2[h];
                        m_cnt[h] = 0;
                        rs[h] = m_s2[h];
                    end
                end
            end else m_cnt[h] = 0;
        end
        n = $countones(rs);
        nd = 1'b0;
        if (m_mode == 0) begin
            if (n > 0) begin
                for (int h = 5; h >= 0; h--) if (rs[h]) m_hid = h;
                m_mode = 1;
                nd = (n > 1);
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_left = LOCK;
            nd = (n > 0);
        end else begin
            nd = (n > 0);
            if (t) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        if (nd) begin
            m_total++;
            if (m_drop < 255) m_drop++;
        end
        m_s2 = m_s1;
        m_s1 = r;
    endtask

    task automatic cycle(input logic [5:0] r);
        logic [12:0] act, exp;
        raw  = r;
        tick = fast ? 1'b1 : (cyc % 10 == 9);
        if (busy && tick && !sense_pulse) lock_ticks++;
        @(posedge clk);
        model_step(r, tick);
        cyc++;
        #1;
        act = {sense_pulse, busy, hole_id, drop_cnt};
        exp = {m_mode == 1, m_mode != 0, 3'(m_hid), 8'(m_drop)};
        cmp("model", int'(act), int'(exp));
        if (sense_pulse) pulses++;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        model_reset();
        repeat (3) cycle('0);
        Reset_n = 1'b1;
        pulses = 0;
        lock_ticks = 0;
    endtask

    typedef struct {
        string      name;
        logic [5:0] a;
        logic [5:0] b;
        int         per;
        int         len;
        int         exp_pulses;
        int         exp_id;
        int         exp_drop;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit got;
        int t;
        logic [5:0] r;

        vecs[0] = '{"single_h2",  6'b000100, 6'b000100, 1000, 60,  1, 2, 0};
        vecs[1] = '{"bounce_h0",  6'b000001, 6'b000000, 7,    100, 0, 0, 0};
        vecs[2] = '{"simul_h1h4", 6'b010010, 6'b010010, 1000, 60,  1, 1, 1};
        vecs[3] = '{"long_h2",    6'b000100, 6'b000100, 1000, 200, 1, 2, 0};
        vecs[4] = '{"simul_h3h5", 6'b101000, 6'b101000, 1000, 60,  1, 3, 1};
        vecs[5] = '{"bounce_all", 6'b111111, 6'b000000, 5,    120, 0, 0, 0};

        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        cmp("rst_pulse", int'(sense_pulse), 0);
        cmp("rst_busy",  int'(busy), 0);
        cmp("rst_id",    int'(hole_id), 0);
        cmp("rst_drop",  int'(drop_cnt), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].len; i++)
                cycle(((i / vecs[v].per) % 2) ? vecs[v].b : vecs[v].a);
            repeat (150) cycle('0);
            cmp({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
            cmp({vecs[v].name, "_id"}, int'(hole_id), vecs[v].exp_id);
            cmp({vecs[v].name, "_drop"}, int'(drop_cnt), vecs[v].exp_drop);
            cmp({vecs[v].name, "_lockticks"}, lock_ticks, LOCK * vecs[v].exp_pulses);
        end

        do_reset();
        repeat (20) cycle(6'b100000);
        repeat (150) cycle(6'b101000);
        cmp("lockout_pulses", pulses, 1);
        cmp("lockout_id", int'(hole_id), 5);
        cmp("lockout_drop", int'(drop_cnt), 1);
        repeat (100) cycle(6'b100000);
        cmp("lockout_idle", int'(busy), 0);
        repeat (80) cycle(6'b101000);
        cmp("rerise_pulses", pulses, 2);
        cmp("rerise_id", int'(hole_id), 3);
        cmp("rerise_drop", int'(drop_cnt), 1);

        do_reset();
        got = 1'b0;
        for (t = 0; t < 80 && !got; t++) begin
            cycle(6'b000010);
            got = sense_pulse;
        end
        cmp("midrst_first_event", int'(got), 1);
        repeat (15) cycle(6'b000010);
        cmp("midrst_in_lockout", int'(busy), 1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        cmp("midrst_pulse", int'(sense_pulse), 0);
        cmp("midrst_busy",  int'(busy), 0);
        cmp("midrst_id",    int'(hole_id), 0);
        cmp("midrst_drop",  int'(drop_cnt), 0);
        repeat (3) cycle(6'b000010);
        Reset_n = 1'b1;
        got = 1'b0;
        for (t = 0; t < 80 && !got; t++) begin
            cycle(6'b000010);
            got = sense_pulse;
        end
        cmp("midrst_held_event", int'(got), 1);
        cmp("midrst_held_id", int'(hole_id), 1);

        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            r = 6'($urandom & $urandom);
            repeat ($urandom_range(5, 80)) cycle(r);
        end

        do_reset();
        m_total = 0;
        fast = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            for (int h = 0; h < 6; h++) r[h] = ((cyc + 2 * h) / 6) % 2 == 1;
            cycle(r);
        end
        cmp("sat_enough_edges", int'(m_total >= 300), 1);
        cmp("sat_value", int'(drop_cnt), 255);
        for (int i = 0; i < 200; i++) begin
            for (int h = 0; h < 6; h++) r[h] = ((cyc + 2 * h) / 6) % 2 == 1;
            cycle(r);
        end
        cmp("sat_no_wrap", int'(drop_cnt), 255);
        fast = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
